// File: rtl/ray_generator.sv
// rtl/ray_generator.sv - per-pixel primary ray generator feeding the ray tracer input FIFO
// Directions are built incrementally: column step du along a row, row step dv at each row wrap.
module ray_generator #(
   parameter int D_BITS = 32,
   parameter int Q_BITS = 10,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic                                     start,
   input  logic signed [D_BITS-1:0]                 cam_origin [3],
   input  logic signed [D_BITS-1:0]                 dir_base [3],
   input  logic signed [D_BITS-1:0]                 du [3],
   input  logic signed [D_BITS-1:0]                 dv [3],
   input  logic                                     full,
   output logic signed [D_BITS-1:0]                 ray_out [6],
   output logic                                     wr_en,
   output logic                                     busy,
   output logic                                     done,
   output logic [$clog2(IMG_W*IMG_H+1)-1:0]         ray_count
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (IMG_W < 1 || IMG_H < 1 || Q_BITS < 0 || Q_BITS >= D_BITS) begin : g_bad_params
      $error("ray_generator: invalid image size or fixed-point format");
   end

   logic [1:0]               state;
   logic [XW-1:0]            x;
   logic [YW-1:0]            y;
   logic signed [D_BITS-1:0] org_r [3];
   logic signed [D_BITS-1:0] du_r  [3];
   logic signed [D_BITS-1:0] dv_r  [3];
   logic signed [D_BITS-1:0] row_r [3];
   logic signed [D_BITS-1:0] dir_r [3];

   assign busy  = (state == S_RUN);
   assign done  = (state == S_DONE);
   assign wr_en = busy && !full;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         ray_out[k]     = org_r[k];
         ray_out[k + 3] = dir_r[k];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= S_IDLE;
         x         <= '0;
         y         <= '0;
         ray_count <= '0;
         for (int k = 0; k < 3; k++) begin
            org_r[k] <= '0;
            du_r[k]  <= '0;
            dv_r[k]  <= '0;
            row_r[k] <= '0;
            dir_r[k] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_RUN;
                  x         <= '0;
                  y         <= '0;
                  ray_count <= '0;
                  for (int k = 0; k < 3; k++) begin
                     org_r[k] <= cam_origin[k];
                     du_r[k]  <= du[k];
                     dv_r[k]  <= dv[k];
                     row_r[k] <= dir_base[k];
                     dir_r[k] <= dir_base[k];
                  end
               end
            end
            S_RUN: begin
               // Everything advances only when the presented ray is accepted.
               if (!full) begin
                  ray_count <= ray_count + 1'b1;
                  if (x == X_LAST) begin
                     x <= '0;
                     y <= y + 1'b1;
                     for (int k = 0; k < 3; k++) begin
                        row_r[k] <= row_r[k] + dv_r[k];
                        dir_r[k] <= row_r[k] + dv_r[k];
                     end
                     if (y == Y_LAST) state <= S_DONE;
                  end else begin
                     x <= x + 1'b1;
                     for (int k = 0; k < 3; k++) dir_r[k] <= dir_r[k] + du_r[k];
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
